mmcm_ps_stepper: RTL and testbench

//  Upstream controller for the MMCM dynamic fine phase-shift port (PSEN/PSINCDEC/PSDONE).

---
 rtl/mmcm_ps_stepper.sv | 141 ++++++++++++++
 tb/tb_mmcm_ps_stepper.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_ps_stepper.sv
// Walks the MMCM fine phase shift to an absolute target by the shortest path around the circle,
// one PSEN/PSDONE handshake per step, tracking position and flagging timeouts and lock loss.
module mmcm_ps_stepper #(
  parameter int unsigned POS_W            = 16,
  parameter int unsigned STEPS_PER_PERIOD = 560,
  parameter int unsigned TIMEOUT          = 64
) (
  input  logic             free_run_clk,
  input  logic             free_run_rst,
  input  logic             locked,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [POS_W-1:0] cmd_target,
  output logic             ps_en,
  output logic             ps_incdec,
  input  logic             ps_done,
  output logic [POS_W-1:0] cur_pos,
  output logic             busy,
  output logic             done,
  output logic             err_range,
  output logic             err_timeout
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [POS_W:0]   N_EXT    = (POS_W+1)'(STEPS_PER_PERIOD);
  localparam logic [POS_W:0]   HALF_EXT = (POS_W+1)'(STEPS_PER_PERIOD / 2);
  localparam logic [POS_W-1:0] N_LAST   = POS_W'(STEPS_PER_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_STEP, S_WAIT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [POS_W-1:0]   target_q, target_d;
  logic [POS_W-1:0]   cur_pos_q, cur_pos_d;
  logic [POS_W-1:0]   remaining_q, remaining_d;
  logic               incdec_q, incdec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_range_q, err_range_d;
  logic               err_timeout_q, err_timeout_d;
  logic [POS_W:0]     diff;

  always_ff @(posedge free_run_clk or posedge free_run_rst) begin
    if (free_run_rst) begin
      state_q       <= S_IDLE;
      target_q      <= '0;
      cur_pos_q     <= '0;
      remaining_q   <= '0;
      incdec_q      <= 1'b0;
      cnt_q         <= '0;
      err_range_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      cur_pos_q     <= cur_pos_d;
      remaining_q   <= remaining_d;
      incdec_q      <= incdec_d;
      cnt_q         <= cnt_d;
      err_range_q   <= err_range_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    cur_pos_d     = cur_pos_q;
    remaining_d   = remaining_q;
    incdec_d      = incdec_q;
    cnt_d         = cnt_q;
    err_range_d   = 1'b0;
    err_timeout_d = err_timeout_q;

    // Forward distance modulo N, one bit wider so target + N cannot overflow.
    if (target_q >= cur_pos_q) diff = {1'b0, target_q} - {1'b0, cur_pos_q};
    else                       diff = {1'b0, target_q} + N_EXT - {1'b0, cur_pos_q};

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if ({1'b0, cmd_target} >= N_EXT) begin
            err_range_d = 1'b1;
          end else begin
            target_d      = cmd_target;
            err_timeout_d = 1'b0;
            state_d       = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (diff == '0) begin
          state_d = S_DONE;
        end else if (diff <= HALF_EXT) begin
          incdec_d    = 1'b1;
          remaining_d = diff[POS_W-1:0];
          state_d     = S_STEP;
        end else begin
          incdec_d    = 1'b0;
          remaining_d = POS_W'(N_EXT - diff);
          state_d     = S_STEP;
        end
      end
      S_STEP: begin
        cnt_d   = CNT_W'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ps_done) begin
          if (incdec_q) cur_pos_d = (cur_pos_q == N_LAST) ? '0 : cur_pos_q + 1'b1;
          else          cur_pos_d = (cur_pos_q == '0) ? N_LAST : cur_pos_q - 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = (remaining_q == POS_W'(1)) ? S_DONE : S_STEP;
        end else if (cnt_q == CNT_MAX) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Relock brings the MMCM back to zero phase, so position tracking restarts there.
    if (!locked) begin
      state_d     = S_IDLE;
      cur_pos_d   = '0;
      remaining_d = '0;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE) && locked;
  assign ps_en       = (state_q == S_STEP);
  assign ps_incdec   = incdec_q;
  assign cur_pos     = cur_pos_q;
  assign busy        = (state_q == S_CALC) || (state_q == S_STEP) || (state_q == S_WAIT);
  assign done        = (state_q == S_DONE);
  assign err_range   = err_range_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mmcm_ps_stepper.sv
// Bench for mmcm_ps_stepper: MMCM handshake model plus a shortest-path position model.
module tb_mmcm_ps_stepper;

  localparam int unsigned N  = 560;
  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        locked;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_target;
  logic        ps_en;
  logic        ps_incdec;
  logic        ps_done;
  logic [15:0] cur_pos;
  logic        busy;
  logic        done;
  logic        err_range;
  logic        err_timeout;

  logic        model_done;
  logic        stray_done;
  assign ps_done = model_done | stray_done;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned lat_cfg = 3;
  int unsigned drop_at_cfg = 0;
  int unsigned drop_base = 0;
  int unsigned pulse_total = 0;
  int unsigned done_tot = 0;
  int unsigned inc_tot = 0;
  int unsigned dec_tot = 0;
  int unsigned model_pos = 0;

  always #5 clk = ~clk;

  mmcm_ps_stepper #(.POS_W(16), .STEPS_PER_PERIOD(N), .TIMEOUT(TO)) dut (
    .free_run_clk (clk),
    .free_run_rst (rst),
    .locked       (locked),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_target   (cmd_target),
    .ps_en        (ps_en),
    .ps_incdec    (ps_incdec),
    .ps_done      (ps_done),
    .cur_pos      (cur_pos),
    .busy         (busy),
    .done         (done),
    .err_range    (err_range),
    .err_timeout  (err_timeout)
  );

  // MMCM model: answers each PSEN after lat_cfg cycles, optionally swallowing one handshake.
  initial begin
    model_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      while (ps_en === 1'b1) begin
        pulse_total++;
        if (drop_at_cfg != 0 && pulse_total - drop_base == drop_at_cfg) begin
          @(posedge clk); #1;
        end else begin
          repeat (lat_cfg) @(posedge clk);
          #1 model_done = 1'b1;
          @(posedge clk);
          #1 model_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_tot <= done_tot + 1;
    if (ps_en === 1'b1) begin
      if (ps_incdec === 1'b1) inc_tot <= inc_tot + 1;
      else                    dec_tot <= dec_tot + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input int unsigned exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic issue(input int unsigned tgt);
    int unsigned n;
    n = 0;
    @(posedge clk); #1;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_cmd", 32'(cmd_ready), 1);
    cmd_valid  = 1'b1;
    cmd_target = 16'(tgt);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic run_cmd(input string tag, input int unsigned tgt, input int unsigned lat,
                         input int unsigned drop_at);
    int unsigned d, steps, pulses, moved, exp_pos, done0, inc0, dec0, cyc, first_en, last_en, limit;
    bit inc, to, seen;
    lat_cfg     = lat;
    drop_at_cfg = drop_at;
    drop_base   = pulse_total;
    done0 = done_tot;
    inc0  = inc_tot;
    dec0  = dec_tot;
    if (tgt >= N) begin
      issue(tgt);
      check({tag, " err_range"}, 32'(err_range), 1);
      check({tag, " ready"}, 32'(cmd_ready), 1);
      check({tag, " busy"}, 32'(busy), 0);
      @(posedge clk); #1;
      check({tag, " err_range_end"}, 32'(err_range), 0);
      check({tag, " pos"}, 32'(cur_pos), model_pos);
      check({tag, " pulses"}, inc_tot + dec_tot - inc0 - dec0, 0);
      return;
    end
    d = (tgt + N - model_pos) % N;
    inc = 1'b1;
    steps = 0;
    if (d != 0) begin
      if (2 * d <= N) steps = d;
      else begin
        inc   = 1'b0;
        steps = N - d;
      end
    end
    to      = (drop_at != 0 && drop_at <= steps);
    pulses  = to ? drop_at : steps;
    moved   = to ? drop_at - 1 : steps;
    exp_pos = inc ? (model_pos + moved) % N : (model_pos + N - moved) % N;
    limit   = steps * (lat + 3) + TO + 50;

    issue(tgt);
    check({tag, " busy_after_accept"}, 32'(busy), 1);
    check({tag, " ready_while_busy"}, 32'(cmd_ready), 0);
    check({tag, " err_timeout_cleared"}, 32'(err_timeout), 0);

    cyc = 0; first_en = 0; last_en = 0; seen = 1'b0;
    while (!seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (ps_en === 1'b1) begin
        if (first_en == 0) first_en = cyc;
        last_en = cyc;
      end
      if (to ? (err_timeout === 1'b1) : (done === 1'b1)) seen = 1'b1;
    end
    check({tag, " completes"}, 32'(seen), 1);
    if (steps == 0) check({tag, " done_latency"}, cyc, 2);
    else            check({tag, " first_psen_latency"}, first_en, 2);
    if (to) check({tag, " timeout_cycles"}, cyc - last_en, TO + 1);
    check({tag, " pos"}, 32'(cur_pos), exp_pos);
    check({tag, " busy_end"}, 32'(busy), 0);
    if (steps != 0) check({tag, " incdec"}, 32'(ps_incdec), 32'(inc));

    @(posedge clk); #2;
    check({tag, " done_one_cycle"}, 32'(done), 0);
    check({tag, " err_timeout"}, 32'(err_timeout), 32'(to));
    check({tag, " ready_end"}, 32'(cmd_ready), 1);
    check({tag, " done_count"}, done_tot - done0, to ? 0 : 1);
    check({tag, " inc_pulses"}, inc_tot - inc0, inc ? pulses : 0);
    check({tag, " dec_pulses"}, dec_tot - dec0, inc ? 0 : pulses);
    model_pos = exp_pos;
  endtask

  initial begin
    int unsigned n, d0;
    rst = 1'b1; locked = 1'b1; cmd_valid = 1'b0; cmd_target = '0; stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst ps_en", 32'(ps_en), 0);
    check("rst ps_incdec", 32'(ps_incdec), 0);
    check("rst cur_pos", 32'(cur_pos), 0);
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst err_range", 32'(err_range), 0);
    check("rst err_timeout", 32'(err_timeout), 0);
    check("rst cmd_ready", 32'(cmd_ready), 1);
    rst = 1'b0;

    run_cmd("zero_move", 0, 3, 0);
    run_cmd("inc5", 5, 3, 0);
    run_cmd("wrap_dec", 555, 3, 0);
    run_cmd("wrap_inc", 0, 2, 0);
    run_cmd("tie_inc", 280, 1, 0);
    run_cmd("range", 560, 3, 0);

    // Stray PSDONE while idle must not move the position.
    @(posedge clk); #1;
    stray_done = 1'b1;
    @(posedge clk); #1;
    stray_done = 1'b0;
    @(posedge clk); #1;
    check("stray pos", 32'(cur_pos), model_pos);
    check("stray busy", 32'(busy), 0);

    run_cmd("tie_back", 0, 1, 0);
    run_cmd("timeout", 10, 3, 3);
    run_cmd("after_timeout", 4, 3, 0);

    lat_cfg = 3; drop_at_cfg = 0;
    d0 = done_tot;
    issue(20);
    n = 0;
    while (cur_pos !== 16'd7 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("lock reached_7", 32'(cur_pos), 7);
    locked = 1'b0;
    @(posedge clk); #1;
    check("lock cur_pos", 32'(cur_pos), 0);
    check("lock busy", 32'(busy), 0);
    check("lock ps_en", 32'(ps_en), 0);
    check("lock ready", 32'(cmd_ready), 0);
    repeat (12) @(posedge clk);
    #1;
    check("lock ready_held", 32'(cmd_ready), 0);
    check("lock no_done", done_tot - d0, 0);
    check("lock pos_held", 32'(cur_pos), 0);
    locked = 1'b1;
    #1;
    check("relock ready", 32'(cmd_ready), 1);
    model_pos = 0;
    run_cmd("post_lock", 3, 2, 0);

    lat_cfg = 2;
    issue(100);
    repeat (20) @(posedge clk);
    #1;
    check("midmove busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst cur_pos", 32'(cur_pos), 0);
    check("async_rst busy", 32'(busy), 0);
    check("async_rst ps_en", 32'(ps_en), 0);
    check("async_rst ps_incdec", 32'(ps_incdec), 0);
    check("async_rst done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    model_pos = 0;
    run_cmd("post_rst_wrap", 559, 1, 0);

    for (int i = 0; i < 10; i++) begin
      run_cmd("rand", $urandom_range(0, 599), $urandom_range(1, 4), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
